// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared widths and control-field layout for the MIPS pipeline stage registers
package mips_pipe_pkg;

   localparam int CTRL_MAX_W = 32;
   typedef logic [CTRL_MAX_W-1:0] ctrl_max_t;
   localparam ctrl_max_t CTRL_NOP = '0;

   localparam int IF_ID_CTRL_W  = 16;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 16;
   localparam int ID_EX_DATA_W  = 128;
   localparam int EX_MEM_CTRL_W = 16;
   localparam int EX_MEM_DATA_W = 96;
   localparam int MEM_WB_CTRL_W = 16;
   localparam int MEM_WB_DATA_W = 96;

   // Control-field bit positions; fields not used by a stage are simply left zero.
   localparam int ALU_OP_LSB    = 0;
   localparam int ALU_OP_W      = 4;
   localparam int LOAD_INSTR    = 4;
   localparam int RF_ENABLE     = 5;
   localparam int HI_ENABLE     = 6;
   localparam int LO_ENABLE     = 7;
   localparam int PC_PLUS8      = 8;
   localparam int OP_H_S        = 9;
   localparam int MEM_ENABLE    = 10;
   localparam int MEM_READWRITE = 11;
   localparam int MEM_SIZE_LSB  = 12;
   localparam int MEM_SIZE_W    = 2;
   localparam int MEM_SIGNE     = 14;

endpackage

// File: rtl/mips_pipe_stage.sv
// rtl/mips_pipe_stage.sv - elastic pipeline stage register with optional skid entry
// Main entry M always drives the outputs; with SKID=1 a second entry S absorbs the beat accepted during a stall.
module mips_pipe_stage
   import mips_pipe_pkg::*;
#(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 64,
   parameter bit SKID   = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              m_valid_q, m_valid_d;
   logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              in_xfer, out_xfer;

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = m_valid_q & out_ready;
   assign out_valid = m_valid_q;
   assign out_ctrl  = m_valid_q ? m_ctrl_q : CTRL_NOP[CTRL_W-1:0];
   assign out_data  = m_data_q;

   generate
      if (SKID) begin : g_skid
         logic              s_valid_q, s_valid_d;
         logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
         logic [DATA_W-1:0] s_data_q, s_data_d;

         assign in_ready  = !s_valid_q;
         assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

         always_comb begin
            m_valid_d = m_valid_q;
            m_ctrl_d  = m_ctrl_q;
            m_data_d  = m_data_q;
            s_valid_d = s_valid_q;
            s_ctrl_d  = s_ctrl_q;
            s_data_d  = s_data_q;
            // A held skid beat refills M first; input cannot transfer while S is full.
            if (out_xfer && s_valid_q) begin
               m_ctrl_d  = s_ctrl_q;
               m_data_d  = s_data_q;
               s_valid_d = 1'b0;
            end else if (in_xfer) begin
               if (!m_valid_q || out_xfer) begin
                  m_valid_d = 1'b1;
                  m_ctrl_d  = in_ctrl;
                  m_data_d  = in_data;
               end else begin
                  s_valid_d = 1'b1;
                  s_ctrl_d  = in_ctrl;
                  s_data_d  = in_data;
               end
            end else if (out_xfer) begin
               m_valid_d = 1'b0;
            end
            if (flush) begin
               m_valid_d = 1'b0;
               s_valid_d = 1'b0;
            end
         end

         always_ff @(posedge Clk) begin
            if (Reset) begin
               s_valid_q <= 1'b0;
               s_ctrl_q  <= '0;
               s_data_q  <= '0;
            end else begin
               s_valid_q <= s_valid_d;
               s_ctrl_q  <= s_ctrl_d;
               s_data_q  <= s_data_d;
            end
         end
      end else begin : g_single
         assign in_ready  = !m_valid_q | out_ready;
         assign occupancy = {1'b0, m_valid_q};

         always_comb begin
            m_valid_d = m_valid_q;
            m_ctrl_d  = m_ctrl_q;
            m_data_d  = m_data_q;
            if (in_xfer) begin
               m_valid_d = 1'b1;
               m_ctrl_d  = in_ctrl;
               m_data_d  = in_data;
            end else if (out_xfer) begin
               m_valid_d = 1'b0;
            end
            if (flush) m_valid_d = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Reset) begin
         m_valid_q <= 1'b0;
         m_ctrl_q  <= '0;
         m_data_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_ctrl_q  <= m_ctrl_d;
         m_data_q  <= m_data_d;
      end
   end

endmodule

// File: tb/tb_mips_pipe_stage.sv
// tb/tb_mips_pipe_stage.sv - directed bench for the skid and single-entry stage variants
module tb_mips_pipe_stage;

   logic        Clk = 1'b0;
   logic        Reset;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [15:0] a_in_ctrl, a_out_ctrl;
   logic [63:0] a_in_data, a_out_data;
   logic [1:0]  a_occ;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [15:0] b_in_ctrl, b_out_ctrl;
   logic [63:0] b_in_data, b_out_data;
   logic [1:0]  b_occ;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   mips_pipe_stage #(.CTRL_W(16), .DATA_W(64), .SKID(1'b1)) u_skid (
      .Clk(Clk), .Reset(Reset), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
      .occupancy(a_occ)
   );

   mips_pipe_stage #(.CTRL_W(16), .DATA_W(64), .SKID(1'b0)) u_single (
      .Clk(Clk), .Reset(Reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
      .occupancy(b_occ)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic a_offer(input logic [63:0] d);
      a_in_valid = 1'b1;
      a_in_data  = d;
      a_in_ctrl  = 16'h0100 | d[15:0];
   endtask

   initial begin
      Reset = 1'b1;
      a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = 0; a_in_data = 0;
      b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = 0; b_in_data = 0;
      step();
      step();
      Reset = 1'b0;

      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_a_out_ctrl", a_out_ctrl, 0);
      chk("rst_a_out_data", a_out_data, 0);
      chk("rst_a_occ", a_occ, 0);
      chk("rst_a_in_ready", a_in_ready, 1);
      chk("rst_b_out_valid", b_out_valid, 0);
      chk("rst_b_in_ready", b_in_ready, 1);
      chk("rst_b_occ", b_occ, 0);

      // Streaming with out_ready high: one beat per cycle, one-cycle latency.
      a_out_ready = 1'b1;
      for (int d = 1; d <= 4; d++) begin
         a_offer(64'(d));
         chk("stream_in_ready", a_in_ready, 1);
         step();
         chk("stream_out_valid", a_out_valid, 1);
         chk("stream_out_data", a_out_data, 64'(d));
         chk("stream_out_ctrl", a_out_ctrl, 16'h0100 | 16'(d));
         chk("stream_occ", a_occ, 1);
      end

      // Drain with a bubble carrying all-ones control: outputs must be gated.
      a_in_valid = 1'b0;
      a_in_ctrl  = 16'hFFFF;
      step();
      chk("bubble_a_out_valid", a_out_valid, 0);
      chk("bubble_a_out_ctrl", a_out_ctrl, 0);
      chk("bubble_a_occ", a_occ, 0);

      // Stall: 5 lands in M, 6 in S, 7 is refused.
      a_out_ready = 1'b0;
      a_offer(64'd5);
      step();
      chk("stall5_occ", a_occ, 1);
      chk("stall5_in_ready", a_in_ready, 1);
      a_offer(64'd6);
      step();
      chk("stall6_occ", a_occ, 2);
      chk("stall6_in_ready", a_in_ready, 0);
      chk("stall6_out_data", a_out_data, 5);
      a_offer(64'd7);
      step();
      chk("stall7_occ", a_occ, 2);
      chk("stall7_out_data", a_out_data, 5);
      chk("stall7_in_ready", a_in_ready, 0);
      a_out_ready = 1'b1;
      step();
      chk("rel6_out_data", a_out_data, 6);
      chk("rel6_occ", a_occ, 1);
      chk("rel6_in_ready", a_in_ready, 1);
      step();
      chk("rel7_out_data", a_out_data, 7);
      chk("rel7_out_valid", a_out_valid, 1);
      a_in_valid = 1'b0;
      step();
      chk("rel_done_out_valid", a_out_valid, 0);

      // Flush with both entries held and beat 9 offered.
      a_out_ready = 1'b0;
      a_offer(64'd8);
      step();
      a_offer(64'd10);
      step();
      chk("preflush_occ", a_occ, 2);
      a_offer(64'd9);
      a_flush = 1'b1;
      step();
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      chk("flush_out_valid", a_out_valid, 0);
      chk("flush_out_ctrl", a_out_ctrl, 0);
      chk("flush_occ", a_occ, 0);
      chk("flush_out_data_held", a_out_data, 8);
      chk("flush_in_ready", a_in_ready, 1);
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flush_no_beat9", a_out_valid, 0);
      end

      // Single-entry variant: combinational in_ready under stall.
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in_data   = 64'h21;
      b_in_ctrl   = 16'h0021;
      chk("b_empty_in_ready", b_in_ready, 1);
      step();
      chk("b_stall_out_valid", b_out_valid, 1);
      chk("b_stall_in_ready", b_in_ready, 0);
      chk("b_stall_out_data", b_out_data, 64'h21);
      chk("b_stall_occ", b_occ, 1);
      b_in_valid = 1'b0;
      b_in_data  = 64'h99;
      b_in_ctrl  = 16'hFFFF;
      step();
      chk("b_hold_out_data", b_out_data, 64'h21);
      chk("b_hold_out_ctrl", b_out_ctrl, 16'h0021);
      b_out_ready = 1'b1;
      #1;
      chk("b_release_in_ready", b_in_ready, 1);
      step();
      chk("b_bubble_out_valid", b_out_valid, 0);
      chk("b_bubble_out_ctrl", b_out_ctrl, 0);
      chk("b_bubble_occ", b_occ, 0);
      b_in_valid = 1'b1;
      b_in_data  = 64'h23;
      b_in_ctrl  = 16'h0023;
      step();
      chk("b_tp23_out_data", b_out_data, 64'h23);
      b_in_data  = 64'h24;
      b_in_ctrl  = 16'h0024;
      chk("b_tp_in_ready", b_in_ready, 1);
      step();
      chk("b_tp24_out_data", b_out_data, 64'h24);
      chk("b_tp24_out_ctrl", b_out_ctrl, 16'h0024);
      b_in_valid = 1'b0;

      // Reset while the skid variant is stalled with two entries.
      a_out_ready = 1'b0;
      a_offer(64'd11);
      step();
      a_offer(64'd12);
      step();
      chk("prerst_occ", a_occ, 2);
      a_in_valid = 1'b0;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      chk("midrst_out_valid", a_out_valid, 0);
      chk("midrst_out_ctrl", a_out_ctrl, 0);
      chk("midrst_out_data", a_out_data, 0);
      chk("midrst_occ", a_occ, 0);
      chk("midrst_in_ready", a_in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
